// File: rtl/fsb_master.sv
// 68HC000-style front-side-bus initiator: turns Req/Ack transactions into nAS/nUDS/nLDS bus cycles.
// Optional bus-error termination on nBERR is compiled in when FSB_BERR_EN is defined.
module fsb_master #(
    parameter int TIMEOUT = 64,
    parameter int AW      = 23
) (
    input  logic          FCLK,
    input  logic          nRESET,
    input  logic          Req,
    input  logic          Write,
    input  logic [1:0]    BE,
    input  logic [AW-1:0] ReqAddr,
    input  logic [15:0]   WrData,
    output logic          Idle,
    output logic          Ack,
    output logic          Err,
    output logic          Vpa,
    output logic [15:0]   RdData,
    output logic [AW-1:0] A,
    output logic          RnW,
    output logic          nAS,
    output logic          nUDS,
    output logic          nLDS,
    output logic [15:0]   Dout,
    output logic          DOE,
    input  logic [15:0]   D,
    input  logic          nDTACK,
    input  logic          nVPA,
    input  logic          nBERR
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AS, S_DS, S_WAIT, S_LATCH, S_NEG, S_REC
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_write;
    logic [1:0]    r_be;
    logic [1:0]    r_dtack_sync;
    logic [1:0]    r_vpa_sync;

    logic w_dtack_term;
    logic w_vpa_term;
    logic w_berr_term;
    logic w_abort;

    assign w_dtack_term = ~r_dtack_sync[1];
    assign w_vpa_term   = ~r_vpa_sync[1];

`ifdef FSB_BERR_EN
    logic [1:0] r_berr_sync;

    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_berr_sync <= 2'b11;
        end else begin
            r_berr_sync <= {r_berr_sync[0], nBERR};
        end
    end

    assign w_berr_term = ~r_berr_sync[1];
`else
    logic w_unused_berr;
    assign w_unused_berr = nBERR;
    assign w_berr_term   = 1'b0;
`endif

    // Bus error wins over any normal termination; timeout only fires when nothing terminated.
    assign w_abort = w_berr_term ||
                     (!w_dtack_term && !w_vpa_term && (r_cnt == CNT_MAX));

    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_be         <= 2'b11;
            r_dtack_sync <= 2'b11;
            r_vpa_sync   <= 2'b11;
            Idle         <= 1'b1;
            Ack          <= 1'b0;
            Err          <= 1'b0;
            Vpa          <= 1'b0;
            RdData       <= '0;
            A            <= '0;
            RnW          <= 1'b1;
            nAS          <= 1'b1;
            nUDS         <= 1'b1;
            nLDS         <= 1'b1;
            Dout         <= '0;
            DOE          <= 1'b0;
        end else begin
            r_dtack_sync <= {r_dtack_sync[0], nDTACK};
            r_vpa_sync   <= {r_vpa_sync[0], nVPA};
            Ack          <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (Req) begin
                        r_write <= Write;
                        r_be    <= (BE == 2'b00) ? 2'b11 : BE;
                        A       <= ReqAddr;
                        RnW     <= ~Write;
                        DOE     <= Write;
                        Dout    <= WrData;
                        Err     <= 1'b0;
                        Vpa     <= 1'b0;
                        Idle    <= 1'b0;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    nAS <= 1'b0;
                    if (!r_write) begin
                        nUDS <= ~r_be[1];
                        nLDS <= ~r_be[0];
                    end
                    r_state <= S_AS;
                end
                S_AS: begin
                    // Write strobes trail nAS so the data bus has settled for two cycles.
                    if (r_write) begin
                        nUDS <= ~r_be[1];
                        nLDS <= ~r_be[0];
                    end
                    r_state <= S_DS;
                end
                S_DS: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_abort) begin
                        Err     <= 1'b1;
                        nAS     <= 1'b1;
                        nUDS    <= 1'b1;
                        nLDS    <= 1'b1;
                        DOE     <= 1'b0;
                        Ack     <= 1'b1;
                        r_state <= S_NEG;
                    end else if (w_dtack_term || w_vpa_term) begin
                        Vpa     <= w_vpa_term;
                        r_state <= S_LATCH;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_LATCH: begin
                    if (!r_write) begin
                        RdData <= D;
                    end
                    nAS     <= 1'b1;
                    nUDS    <= 1'b1;
                    nLDS    <= 1'b1;
                    DOE     <= 1'b0;
                    Ack     <= 1'b1;
                    r_state <= S_NEG;
                end
                S_NEG: begin
                    r_cnt   <= '0;
                    r_state <= S_REC;
                end
                S_REC: begin
                    // A responder that never releases its termination cannot wedge the master.
                    if ((r_dtack_sync[1] && r_vpa_sync[1]) || (r_cnt == CNT_MAX)) begin
                        Idle    <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsb_master.sv
// Scoreboard bench for fsb_master: directed bus cycles push expected Ack responses,
// a negedge monitor pops and compares them; protocol phases are checked inline.
module tb_fsb_master;
    localparam int AW      = 23;
    localparam int TIMEOUT = 64;

    logic          FCLK    = 1'b0;
    logic          nRESET  = 1'b1;
    logic          Req     = 1'b0;
    logic          Write   = 1'b0;
    logic [1:0]    BE      = 2'b11;
    logic [AW-1:0] ReqAddr = '0;
    logic [15:0]   WrData  = '0;
    logic [15:0]   D       = '0;
    logic          nDTACK  = 1'b1;
    logic          nVPA    = 1'b1;
    logic          nBERR   = 1'b1;

    logic          Idle, Ack, Err, Vpa, RnW, nAS, nUDS, nLDS, DOE;
    logic [15:0]   RdData, Dout;
    logic [AW-1:0] A;

    fsb_master #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
        .FCLK(FCLK), .nRESET(nRESET), .Req(Req), .Write(Write), .BE(BE),
        .ReqAddr(ReqAddr), .WrData(WrData), .Idle(Idle), .Ack(Ack), .Err(Err),
        .Vpa(Vpa), .RdData(RdData), .A(A), .RnW(RnW), .nAS(nAS), .nUDS(nUDS),
        .nLDS(nLDS), .Dout(Dout), .DOE(DOE), .D(D), .nDTACK(nDTACK),
        .nVPA(nVPA), .nBERR(nBERR)
    );

    always #5 FCLK = ~FCLK;

    typedef struct {
        string       name;
        logic        err;
        logic        vpa;
        logic [15:0] rd;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input string name, input logic err, input logic vpa,
                            input logic [15:0] rd, input int lat);
        exp_t e;
        e.name = name;
        e.err  = err;
        e.vpa  = vpa;
        e.rd   = rd;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    // Acceptance time: Idle and Req both high just before the edge.
    always @(posedge FCLK) begin
        cyc++;
        if (Idle === 1'b1 && Req === 1'b1) acc_cyc = cyc;
    end

    always @(negedge FCLK) begin
        exp_t e;
        if (Ack === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_ack", 32'(Ack), 0);
            end else begin
                e = sb_q.pop_front();
                chk({e.name, "_err"},     32'(Err),    32'(e.err));
                chk({e.name, "_vpa"},     32'(Vpa),    32'(e.vpa));
                chk({e.name, "_rddata"},  32'(RdData), 32'(e.rd));
                chk({e.name, "_latency"}, cyc - acc_cyc, e.lat);
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] be, input logic [AW-1:0] addr,
                         input logic [15:0] wd);
        @(negedge FCLK);
        Req = 1'b1; Write = wr; BE = be; ReqAddr = addr; WrData = wd;
        @(negedge FCLK);
        Req = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (Ack !== 1'b1 && n < 200) begin
            @(negedge FCLK);
            n++;
        end
        chk({name, "_ack_seen"}, 32'(Ack), 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (Idle !== 1'b1 && n < 200) begin
            @(negedge FCLK);
            n++;
        end
        chk({name, "_idle"}, 32'(Idle), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=running expected=finished");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_bad;
        #1 nRESET = 1'b0;
        repeat (3) @(negedge FCLK);
        chk("rst_strobes", 32'({nAS, nUDS, nLDS, RnW}), 'hF);
        chk("rst_doe",     32'(DOE), 0);
        chk("rst_idle",    32'(Idle), 1);
        chk("rst_flags",   32'({Ack, Err, Vpa}), 0);
        chk("rst_rddata",  32'(RdData), 0);
        chk("rst_a",       32'(A), 0);
        chk("rst_dout",    32'(Dout), 0);
        nRESET = 1'b1;
        repeat (2) @(negedge FCLK);

        // Read, DTACK already low
        nDTACK = 1'b0; D = 16'hA55A;
        push_exp("rd", 1'b0, 1'b0, 16'hA55A, 5);
        issue(1'b0, 2'b11, 23'h012345, 16'h0000);
        chk("rd_addr_phase", 32'({nAS, nUDS, nLDS, RnW, DOE}), 'b11110);
        chk("rd_a",          32'(A), 'h012345);
        chk("rd_busy",       32'(Idle), 0);
        @(negedge FCLK);
        chk("rd_as_phase",   32'({nAS, nUDS, nLDS}), 'b000);
        wait_ack("rd");
        chk("rd_a_hold",     32'(A), 'h012345);
        nDTACK = 1'b1;
        wait_idle("rd");

        // Write, upper byte only
        nDTACK = 1'b0; D = 16'h0000;
        push_exp("wr", 1'b0, 1'b0, 16'hA55A, 5);
        issue(1'b1, 2'b10, 23'h000040, 16'h1234);
        chk("wr_addr_phase", 32'({nAS, nUDS, nLDS, RnW, DOE}), 'b11101);
        chk("wr_dout",       32'(Dout), 'h1234);
        @(negedge FCLK);
        chk("wr_as_phase",   32'({nAS, nUDS, nLDS}), 'b011);
        @(negedge FCLK);
        chk("wr_ds_phase",   32'({nAS, nUDS, nLDS, DOE}), 'b0011);
        wait_ack("wr");
        chk("wr_neg_phase",  32'({nAS, nUDS, nLDS, DOE}), 'b1110);
        nDTACK = 1'b1;
        wait_idle("wr");

        // VPA-only termination, responder holds nVPA 10 extra cycles
        nVPA = 1'b0; D = 16'h5AA5;
        push_exp("vpa", 1'b0, 1'b1, 16'h5AA5, 5);
        issue(1'b0, 2'b01, 23'h000100, 16'h0000);
        @(negedge FCLK);
        chk("vpa_as_phase", 32'({nAS, nUDS, nLDS}), 'b010);
        wait_ack("vpa");
        busy_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge FCLK);
            if (Idle !== 1'b0) busy_bad++;
        end
        chk("vpa_hold_busy", busy_bad, 0);
        nVPA = 1'b1;
        @(negedge FCLK);
        @(negedge FCLK);
        chk("vpa_sync_busy", 32'(Idle), 0);
        @(negedge FCLK);
        chk("vpa_release_idle", 32'(Idle), 1);

        // DTACK and VPA together; BE=00 behaves as 11
        nDTACK = 1'b0; nVPA = 1'b0; D = 16'h0F0F;
        push_exp("both", 1'b0, 1'b1, 16'h0F0F, 5);
        issue(1'b0, 2'b00, 23'h7FFFFF, 16'h0000);
        @(negedge FCLK);
        chk("be00_as_phase", 32'({nAS, nUDS, nLDS}), 'b000);
        wait_ack("both");
        nDTACK = 1'b1; nVPA = 1'b1;
        wait_idle("both");

        // Timeout: no termination, 64 WAIT cycles
        D = 16'hDEAD;
        push_exp("tmo", 1'b1, 1'b0, 16'h0F0F, 3 + TIMEOUT);
        issue(1'b0, 2'b11, 23'h000002, 16'h0000);
        chk("tmo_flags_cleared", 32'({Err, Vpa}), 0);
        wait_ack("tmo");
        wait_idle("tmo");

        // Asynchronous reset while in WAIT
        issue(1'b1, 2'b11, 23'h000ABC, 16'hCAFE);
        repeat (4) @(negedge FCLK);
        chk("rstw_in_wait", 32'({nAS, nUDS, nLDS, DOE}), 'b0001);
        #2 nRESET = 1'b0;
        #1;
        chk("rstw_bus_release", 32'({nAS, nUDS, nLDS, DOE}), 'b1110);
        chk("rstw_no_ack",      32'(Ack), 0);
        @(negedge FCLK);
        nRESET = 1'b1;
        repeat (3) @(negedge FCLK);
        chk("rstw_idle",   32'(Idle), 1);
        chk("rstw_rddata", 32'(RdData), 0);

`ifdef FSB_BERR_EN
        // BERR and DTACK in the same cycle: BERR wins, LATCH skipped
        nBERR = 1'b0; nDTACK = 1'b0; D = 16'hBEEF;
        push_exp("berr", 1'b1, 1'b0, 16'h0000, 4);
`else
        // nBERR is ignored in this build
        nBERR = 1'b0; nDTACK = 1'b0; D = 16'hBEEF;
        push_exp("berr_ignored", 1'b0, 1'b0, 16'hBEEF, 5);
`endif
        issue(1'b0, 2'b11, 23'h000200, 16'h0000);
        wait_ack("berr");
        nBERR = 1'b1; nDTACK = 1'b1;
        wait_idle("berr");

        repeat (5) @(negedge FCLK);
        chk("sb_drain", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fsb_master.md
Name: fsb_master

Overview:
- 68HC000-style front-side-bus initiator.
- Converts a simple request/acknowledge interface from internal logic (DMA, debug port) into asynchronous bus cycles: drives nAS, nUDS, nLDS, RnW, address and write data.
- Waits for responder termination on nDTACK or nVPA and returns read data and status.
- Pairs with the FSB responder on the same bus, which drives nDTACK/nVPA.

Parameters:
- TIMEOUT, 64, WAIT-state cycles before a cycle is aborted with Err.
- AW, 23, address width (A[23:1]).

Ports:
- FCLK  in  1  bus clock; all state on posedge.
- nRESET  in  1  asynchronous, active-low reset.
- Req  in  1  start cycle; sampled only while Idle=1.
- Write  in  1  1=write, 0=read.
- BE  in  2  byte enables {upper,lower}; 2'b00 treated as 2'b11.
- ReqAddr  in  AW  word address.
- WrData  in  16  write data.
- Idle  out  1  ready to accept Req.
- Ack  out  1  one-cycle completion pulse.
- Err  out  1  valid with Ack; timeout (or BERR) termination.
- Vpa  out  1  valid with Ack; cycle was terminated by nVPA.
- RdData  out  16  read data; valid from Ack until next acceptance.
- A  out  AW  bus address.
- RnW  out  1  bus read/write.
- nAS, nUDS, nLDS  out  1 each  bus strobes.
- Dout  out  16  bus write data.
- DOE  out  1  data-bus output enable.
- D  in  16  bus read data.
- nDTACK, nVPA, nBERR  in  1 each  responder termination.

Behaviour:
- Reset (async, nRESET=0):
  - state IDLE; nAS=nUDS=nLDS=1, RnW=1, DOE=0.
  - Ack=Err=Vpa=0, RdData=0, A=0, Dout=0.
  - Takes effect immediately, including mid-cycle; strobes release without an Ack.
- Synchronizers: nDTACK, nVPA, nBERR each pass through 2 FCLK flops; "term" below means a synchronized low.
- All outputs are registered. States: IDLE, ADDR, AS, DS, WAIT, LATCH, NEG, REC.
- IDLE:
  - Idle=1.
  - On Req=1: latch Write/BE/ReqAddr/WrData; drive A and RnW=~Write; DOE=Write; Dout=WrData; go to ADDR.
- ADDR (1 cycle): address and RnW stable, strobes high.
- AS (1 cycle): nAS=0. For reads, nUDS=~BE[1] and nLDS=~BE[0] also assert here.
- DS (1 cycle): for writes, nUDS/nLDS assert here (data already stable ≥2 cycles). Reads pass through unchanged.
- WAIT:
  - Wait-cycle counter cleared on entry.
  - Synchronized DTACK term → LATCH.
  - Synchronized VPA term → LATCH with Vpa flag set.
  - If both terminate together, Vpa=1.
  - Counter reaching TIMEOUT-1 with no term → NEG with Err=1.
- LATCH: RdData <= D for reads; writes leave RdData unchanged.
- NEG:
  - nAS=nUDS=nLDS=1, DOE=0.
  - Ack=1 for exactly this cycle, with Err and Vpa valid.
- REC:
  - Wait until synchronized nDTACK=1 and nVPA=1, then IDLE.
  - Bounded by the same counter (restarted at entry): at TIMEOUT-1, go to IDLE regardless. No second Ack.
- Latency: with nDTACK already low, Ack asserts in the 5th cycle after acceptance (states ADDR, AS, DS, WAIT, LATCH, then NEG). Each extra synchronizer delay adds one WAIT cycle.
- Back-to-back: Req held high is re-accepted only in IDLE. Minimum spacing is 8 cycles.
- Err and Vpa are cleared at acceptance.
- RdData on an Err cycle keeps its prior value.

Optional Feature:
- FSB_BERR_EN defined:
  - Synchronized nBERR low in WAIT → NEG with Err=1; LATCH is skipped.
  - BERR has priority over DTACK/VPA in the same cycle.
- FSB_BERR_EN undefined: nBERR is ignored (port retained, synchronizer omitted). Only timeout sets Err.

Test Plan:
- Read, nDTACK held low, D=16'hA55A, BE=2'b11, ReqAddr=23'h012345:
  - nAS and both DS low from the AS cycle.
  - Ack in the 5th cycle after acceptance with Err=0, Vpa=0; RdData=16'hA55A; A=23'h012345 throughout.
- Write, BE=2'b10, WrData=16'h1234:
  - DOE=1 and Dout=16'h1234 from ADDR.
  - nUDS low one cycle after nAS; nLDS stays high.
  - DOE=0 in the NEG cycle.
- Read, nDTACK never asserted, TIMEOUT=64: Ack with Err=1 after 64 WAIT cycles; RdData unchanged; returns to Idle=1.
- Read terminated by nVPA low only: Ack with Vpa=1, Err=0. Responder holds nVPA low 10 more cycles → Idle stays 0 until it is released plus 2 synchronizer cycles.
- Reset pulse while in WAIT: nAS/nUDS/nLDS go high and DOE goes 0 without waiting for FCLK; no Ack; after release, Idle=1.
- FSB_BERR_EN defined, nBERR and nDTACK low in the same cycle: Ack with Err=1; RdData unchanged.
